// File: rtl/vga_rect_fill.sv
// ---------------------------------------------------------------------------
// vga_rect_fill
//
// Feeds the VGA driver's framebuffer write port. It accepts rectangle-fill
// commands and clips each one to the 400x300 half-resolution framebuffer.
// It then streams one pixel write per clock in raster order. A direct CPU
// pixel-write port is merged in and always wins over fill traffic.
//
// Ports:
//   clk50M        system clock
//   rst_n         asynchronous active-low reset
//   cmd_valid     fill command present
//   cmd_ready     command can be accepted (high only while idle)
//   cmd_x0/cmd_y0 rectangle top-left corner
//   cmd_w/cmd_h   rectangle size in pixels
//   cmd_color     RRRGGGBB fill colour
//   cpu_we        direct pixel write strobe
//   cpu_addr      direct write address
//   cpu_data      direct write data
//   write_addr    framebuffer write address (registered)
//   write_data    framebuffer write data (registered)
//   write_enable  framebuffer write strobe (registered)
//   busy          a command is in progress
//   done          one-cycle pulse when a command finishes
// ---------------------------------------------------------------------------
module vga_rect_fill #(
   parameter int ADDR_WIDTH  = 18,
   parameter int WIDTH_SHIFT = 9,
   parameter int FB_W        = 400,
   parameter int FB_H        = 300
) (
   input  logic                  clk50M,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [8:0]            cmd_x0,
   input  logic [8:0]            cmd_y0,
   input  logic [8:0]            cmd_w,
   input  logic [8:0]            cmd_h,
   input  logic [7:0]            cmd_color,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [7:0]            cpu_data,
   output logic [ADDR_WIDTH-1:0] write_addr,
   output logic [7:0]            write_data,
   output logic                  write_enable,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      IDLE,
      CLIP,
      FILL
   } state_t;

   state_t state;
   state_t next_state;

   logic [8:0]            lat_x0;
   logic [8:0]            lat_y0;
   logic [8:0]            lat_w;
   logic [8:0]            lat_h;
   logic [7:0]            lat_color;
   logic [8:0]            cur_x;
   logic [8:0]            cur_y;
   logic [9:0]            x_last;
   logic [9:0]            y_last;

   logic                  cmd_empty;
   logic [9:0]            room_x;
   logic [9:0]            room_y;
   logic [9:0]            wc;
   logic [9:0]            hc;
   logic [9:0]            x_last_calc;
   logic [9:0]            y_last_calc;
   logic                  at_row_end;
   logic                  at_last_pixel;
   logic [ADDR_WIDTH-1:0] fill_addr;

   // Clipping is done in 10 bits so that x0+w and FB_W-x0 cannot overflow.
   // room_x/room_y only have meaning when the command is non-empty, which
   // is the only case in which they are used.
   assign cmd_empty   = ({1'b0, lat_x0} >= 10'(FB_W)) ||
                        ({1'b0, lat_y0} >= 10'(FB_H)) ||
                        (lat_w == 9'd0) || (lat_h == 9'd0);
   assign room_x      = 10'(FB_W) - {1'b0, lat_x0};
   assign room_y      = 10'(FB_H) - {1'b0, lat_y0};
   assign wc          = ({1'b0, lat_w} < room_x) ? {1'b0, lat_w} : room_x;
   assign hc          = ({1'b0, lat_h} < room_y) ? {1'b0, lat_h} : room_y;
   assign x_last_calc = {1'b0, lat_x0} + wc - 10'd1;
   assign y_last_calc = {1'b0, lat_y0} + hc - 10'd1;

   // Scan position relative to the clipped rectangle's far corner.
   assign at_row_end    = ({1'b0, cur_x} == x_last);
   assign at_last_pixel = at_row_end && ({1'b0, cur_y} == y_last);

   // The row stride is a power of two, so the address is a concatenation plus x.
   assign fill_addr = ADDR_WIDTH'({cur_y, {WIDTH_SHIFT{1'b0}}}) + ADDR_WIDTH'(cur_x);

   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   // State register. An in-flight fill is simply dropped by reset.
   always_ff @(posedge clk50M or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. In FILL, the last pixel only counts once it has
   // actually been issued. A CPU write in that cycle stalls the fill, so
   // the FSM stays in FILL.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               next_state = CLIP;
            end
         end
         CLIP: begin
            next_state = cmd_empty ? IDLE : FILL;
         end
         FILL: begin
            if (!cpu_we && at_last_pixel) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Datapath: command latch, scan counters and the registered write port.
   // The CPU write is applied last, so it overrides any fill pixel. The fill
   // branch also refuses to issue or advance while cpu_we is high, so a
   // stalled pixel is retried rather than lost.
   always_ff @(posedge clk50M or negedge rst_n) begin
      if (!rst_n) begin
         lat_x0       <= '0;
         lat_y0       <= '0;
         lat_w        <= '0;
         lat_h        <= '0;
         lat_color    <= '0;
         cur_x        <= '0;
         cur_y        <= '0;
         x_last       <= '0;
         y_last       <= '0;
         write_addr   <= '0;
         write_data   <= '0;
         write_enable <= 1'b0;
         done         <= 1'b0;
      end else begin
         write_enable <= 1'b0;
         done         <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  lat_x0    <= cmd_x0;
                  lat_y0    <= cmd_y0;
                  lat_w     <= cmd_w;
                  lat_h     <= cmd_h;
                  lat_color <= cmd_color;
               end
            end
            CLIP: begin
               if (cmd_empty) begin
                  done <= 1'b1;
               end else begin
                  cur_x  <= lat_x0;
                  cur_y  <= lat_y0;
                  x_last <= x_last_calc;
                  y_last <= y_last_calc;
               end
            end
            FILL: begin
               if (!cpu_we) begin
                  write_addr   <= fill_addr;
                  write_data   <= lat_color;
                  write_enable <= 1'b1;
                  if (at_last_pixel) begin
                     done <= 1'b1;
                  end
                  if (at_row_end) begin
                     cur_x <= lat_x0;
                     cur_y <= cur_y + 9'd1;
                  end else begin
                     cur_x <= cur_x + 9'd1;
                  end
               end
            end
            default: begin
            end
         endcase
         if (cpu_we) begin
            write_addr   <= cpu_addr;
            write_data   <= cpu_data;
            write_enable <= 1'b1;
         end
      end
   end

endmodule
